// File: rtl/triangle_driver.sv
`default_nettype none
// ============================================================================
// triangle_driver : host-side driver for the triangle rasterizer; sends three
//                   vertices, collects emitted points into an 8x8 bitmap.
// Optional: TRI_DRV_ORDER_CHK_EN flags points arriving out of raster order.
// Revision: 1.0
// ============================================================================
module triangle_driver #(
    parameter int TIMEOUT = 128
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [17:0] vtx,
    input  logic        busy,
    input  logic        po,
    input  logic [2:0]  xo,
    input  logic [2:0]  yo,
    output logic        nt,
    output logic [2:0]  xi,
    output logic [2:0]  yi,
    output logic        ready,
    output logic        done,
    output logic        err,
    output logic [63:0] bitmap,
    output logic [6:0]  count
);

    localparam int            TW     = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SEND1     = 3'd1,
        SEND2     = 3'd2,
        SEND3     = 3'd3,
        WAIT_BUSY = 3'd4,
        COLLECT   = 3'd5,
        FINISH    = 3'd6
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [TW-1:0] timer;
    logic [11:0]   vtx_hold;
    logic          accept;
    logic          capture;
    logic          new_point;
    logic          timer_last;
    logic          timeout_hit;
    logic          waiting;
    logic [5:0]    idx;
    logic          order_err;

    assign accept     = (state == IDLE) && start;
    assign waiting    = (state == WAIT_BUSY) || (state == COLLECT);
    assign capture    = po && waiting;
    assign idx        = {yo, xo};
    assign new_point  = capture && !bitmap[idx];
    assign timer_last = (timer == T_LAST);

    // ready is gated by reset so every output reads 0 while reset is held
    assign ready = (state == IDLE) && reset;
    assign done  = (state == FINISH);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        timeout_hit = 1'b0;
        case (state)
            IDLE:      if (start) state_next = SEND1;
            SEND1:     state_next = SEND2;
            SEND2:     state_next = SEND3;
            SEND3:     state_next = WAIT_BUSY;
            WAIT_BUSY: begin
                if (busy) begin
                    state_next = COLLECT;
                end else if (timer_last) begin
                    timeout_hit = 1'b1;
                    state_next  = FINISH;
                end
            end
            COLLECT: begin
                if (!busy) begin
                    state_next = FINISH;
                end else if (!po && timer_last) begin
                    timeout_hit = 1'b1;
                    state_next  = FINISH;
                end
            end
            FINISH:    state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // Timer restarts on every state entry and on each point while collecting
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer <= '0;
        end else if (!waiting || (state != state_next) || (state == COLLECT && po)) begin
            timer <= '0;
        end else begin
            timer <= timer + TW'(1);
        end
    end

`ifdef TRI_DRV_ORDER_CHK_EN
    logic [5:0] last_idx;
    logic       have_pt;

    assign order_err = capture && have_pt && (idx <= last_idx);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_idx <= '0;
            have_pt  <= 1'b0;
        end else if (accept) begin
            last_idx <= '0;
            have_pt  <= 1'b0;
        end else if (capture) begin
            last_idx <= idx;
            have_pt  <= 1'b1;
        end
    end
`else
    assign order_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vtx_hold <= '0;
            nt       <= 1'b0;
            xi       <= '0;
            yi       <= '0;
            err      <= 1'b0;
            bitmap   <= '0;
            count    <= '0;
        end else if (accept) begin
            vtx_hold <= vtx[11:0];
            nt       <= 1'b1;
            xi       <= vtx[17:15];
            yi       <= vtx[14:12];
            err      <= 1'b0;
            bitmap   <= '0;
            count    <= '0;
        end else begin
            case (state)
                SEND1: begin
                    nt <= 1'b0;
                    xi <= vtx_hold[11:9];
                    yi <= vtx_hold[8:6];
                end
                SEND2: begin
                    xi <= vtx_hold[5:3];
                    yi <= vtx_hold[2:0];
                end
                default: ;
            endcase
            if (new_point) begin
                bitmap[idx] <= 1'b1;
                if (count != 7'd64) count <= count + 7'd1;
            end
            if (timeout_hit || order_err) err <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_triangle_driver.sv
`default_nettype none
// Scoreboard bench for triangle_driver: expected vertex streams and end-of-
// transaction results are queued at stimulus time and checked by monitors.
module tb_triangle_driver;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [17:0] vtx = '0;
    logic        busy = 1'b0;
    logic        po = 1'b0;
    logic [2:0]  xo = '0;
    logic [2:0]  yo = '0;
    logic        nt;
    logic [2:0]  xi;
    logic [2:0]  yi;
    logic        ready;
    logic        done;
    logic        err;
    logic [63:0] bitmap;
    logic [6:0]  count;

    triangle_driver #(.TIMEOUT(128)) dut (
        .clk(clk), .reset(reset), .start(start), .vtx(vtx), .busy(busy),
        .po(po), .xo(xo), .yo(yo), .nt(nt), .xi(xi), .yi(yi),
        .ready(ready), .done(done), .err(err), .bitmap(bitmap), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] bm;
        logic [6:0]  cnt;
        logic        er;
        int          cyc;
        string       tag;
    } exp_t;

    exp_t        exp_q[$];
    logic [17:0] vq[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    logic [2:0]  px[64];
    logic [2:0]  py[64];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Vertex stream monitor
    always begin
        logic [17:0] v;
        @(negedge clk);
        if (nt) begin
            if (vq.size() == 0) begin
                check("spurious_nt", nt, 0);
            end else begin
                v = vq.pop_front();
                check("v1", {xi, yi}, {v[17:15], v[14:12]});
                @(negedge clk);
                check("nt_width", nt, 0);
                check("v2", {xi, yi}, {v[11:9], v[8:6]});
                @(negedge clk);
                check("v3", {xi, yi}, {v[5:3], v[2:0]});
                @(negedge clk);
                check("v3_hold", {xi, yi}, {v[5:3], v[2:0]});
            end
        end
    end

    // Completion monitor
    always begin
        exp_t e;
        @(negedge clk);
        if (done) begin
            if (exp_q.size() == 0) begin
                check("spurious_done", done, 0);
            end else begin
                e = exp_q.pop_front();
                check({e.tag, "_count"}, count, e.cnt);
                check({e.tag, "_err"}, err, e.er);
                check({e.tag, "_bitmap"}, bitmap, e.bm);
                if (e.cyc >= 0) check({e.tag, "_latency"}, cyc, e.cyc);
            end
        end
    end

    task automatic run_txn(input string tag, input logic [17:0] v, input int n,
                           input bit raise_busy, input bit drop_with_last,
                           input bit hold_start, input bit stall,
                           input logic [63:0] ebm, input logic [6:0] ecnt,
                           input logic eerr, input int lat);
        exp_t e;
        vq.push_back(v);
        @(negedge clk);
        vtx   = v;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        vtx   = ~v;
        check({tag, "_ready_low"}, ready, 0);
        e.bm  = ebm;
        e.cnt = ecnt;
        e.er  = eerr;
        e.cyc = (lat >= 0) ? cyc + lat : -1;
        e.tag = tag;
        exp_q.push_back(e);
        if (raise_busy) begin
            repeat (3) @(negedge clk);
            busy = 1'b1;
            for (int i = 0; i < n; i++) begin
                @(negedge clk);
                po = 1'b1;
                xo = px[i];
                yo = py[i];
                if (hold_start) start = 1'b1;
                if (drop_with_last && i == n - 1) begin
                    busy  = 1'b0;
                    start = 1'b0;
                end
            end
            @(negedge clk);
            po    = 1'b0;
            start = 1'b0;
            if (!stall) busy = 1'b0;
        end
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            check({tag, "_done_seen"}, 0, 1);
            exp_q.delete();
        end
        busy = 1'b0;
        @(negedge clk);
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int n;
        logic        order_err_exp;
        logic        dup_err_exp;
`ifdef TRI_DRV_ORDER_CHK_EN
        order_err_exp = 1'b1;
        dup_err_exp   = 1'b1;
`else
        order_err_exp = 1'b0;
        dup_err_exp   = 1'b0;
`endif
        #12;
        check("rst_nt", nt, 0);
        check("rst_xiyi", {xi, yi}, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_bitmap", bitmap, 0);
        check("rst_count", count, 0);
        check("rst_ready", ready, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("ready_after_rst", ready, 1);

        // Basic triangle (1,1),(5,1),(1,5): points x,y>=1, x+y<=6, raster order;
        // final point arrives in the same cycle busy falls.
        n = 0;
        for (int y = 1; y < 8; y++)
            for (int x = 1; x < 8; x++)
                if (x + y <= 6) begin
                    px[n] = 3'(x);
                    py[n] = 3'(y);
                    n++;
                end
        run_txn("basic", {3'd1, 3'd1, 3'd5, 3'd1, 3'd1, 3'd5}, n, 1, 1, 0, 0,
                64'h0000_0206_0E1E_3E00, 7'd15, 1'b0, -1);

        // Busy never rises: done 131 cycles after the start edge.
        run_txn("busy_to", {3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7}, 0, 0, 0, 0, 0,
                64'h0, 7'd0, 1'b1, 131);

        // Duplicate (3,3) points.
        px[0] = 3'd3; py[0] = 3'd3;
        px[1] = 3'd3; py[1] = 3'd3;
        run_txn("dup", {3'd3, 3'd0, 3'd7, 3'd0, 3'd0, 3'd7}, 2, 1, 0, 0, 0,
                64'h0000_0000_0800_0000, 7'd1, dup_err_exp, -1);

        // Corner indices 0 and 63.
        px[0] = 3'd0; py[0] = 3'd0;
        px[1] = 3'd7; py[1] = 3'd7;
        run_txn("corners", {3'd0, 3'd0, 3'd7, 3'd0, 3'd7, 3'd7}, 2, 1, 1, 0, 0,
                64'h8000_0000_0000_0001, 7'd2, 1'b0, -1);

        // start held high during COLLECT must not trigger a second nt.
        px[0] = 3'd1; py[0] = 3'd1;
        px[1] = 3'd2; py[1] = 3'd1;
        px[2] = 3'd3; py[2] = 3'd1;
        run_txn("hold_start", {3'd1, 3'd1, 3'd3, 3'd1, 3'd1, 3'd3}, 3, 1, 0, 1, 0,
                64'h0000_0000_0000_0E00, 7'd3, 1'b0, -1);

        // Out-of-order points (2,2) then (1,2).
        px[0] = 3'd2; py[0] = 3'd2;
        px[1] = 3'd1; py[1] = 3'd2;
        run_txn("order", {3'd2, 3'd2, 3'd1, 3'd2, 3'd2, 3'd1}, 2, 1, 1, 0, 0,
                64'h0000_0000_0006_0000, 7'd2, order_err_exp, -1);

        // COLLECT timeout with busy stuck high; the point at cycle 5 restarts
        // the timer, so expiry lands at 5+128.
        px[0] = 3'd3; py[0] = 3'd1;
        run_txn("collect_to", {3'd4, 3'd4, 3'd5, 3'd5, 3'd6, 3'd6}, 1, 1, 0, 0, 1,
                64'h0000_0000_0000_0800, 7'd1, 1'b1, 133);

        // Reset mid-COLLECT: outputs clear immediately, no done follows.
        vq.push_back({3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6});
        @(negedge clk);
        vtx   = {3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6};
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        busy = 1'b1;
        @(negedge clk);
        po = 1'b1; xo = 3'd2; yo = 3'd3;
        @(negedge clk);
        po = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("mid_rst_nt", nt, 0);
        check("mid_rst_xiyi", {xi, yi}, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_err", err, 0);
        check("mid_rst_bitmap", bitmap, 0);
        check("mid_rst_count", count, 0);
        check("mid_rst_ready", ready, 0);
        @(negedge clk);
        busy = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("mid_rst_ready_release", ready, 1);
        repeat (6) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
